// File: rtl/snake_frame_render.sv
// Snake game frame renderer: fetches body segments from a sync-read memory,
// paints them plus the apple into a working buffer and commits it to the LED matrix.
module snake_frame_render #(
    parameter int ROWS    = 6,
    parameter int COLS    = 6,
    parameter int MAX_LEN = 16,
    parameter int PW      = $clog2(ROWS*COLS),
    parameter int LW      = $clog2(MAX_LEN+1),
    localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int NPIX   = ROWS*COLS
) (
    input  logic            clock,
    input  logic            restart,
    input  logic            start,
    input  logic [LW-1:0]   size,
    output logic [AW-1:0]   seg_addr,
    input  logic [PW-1:0]   seg_pos,
    input  logic [PW-1:0]   apple_pos,
    input  logic            apple_en,
    input  logic            blink,
    output logic [NPIX-1:0] leds,
    output logic            busy,
    output logic            frame_done,
    output logic            collision,
    output logic            apple_hit,
    output logic            pos_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_APPLE,
        S_COMMIT
    } state_t;

    state_t          r_state;
    logic [NPIX-1:0] r_work;
    logic [NPIX-1:0] r_leds;
    logic [LW-1:0]   r_len;
    logic [AW-1:0]   r_index;
    logic [AW-1:0]   r_pendIdx;
    logic            r_pend;
    logic            r_parity;
    logic            r_colScr;
    logic            r_hitScr;
    logic            r_errScr;
    logic            r_frameDone;
    logic            r_collision;
    logic            r_appleHit;
    logic            r_posError;

    logic [LW-1:0]   w_lenClamp;
    logic            w_segInRange;
    logic            w_appleInRange;
    logic            w_isHead;
    logic            w_writeSeg;
    logic            w_lastFetch;

    assign w_lenClamp     = (size > LW'(MAX_LEN)) ? LW'(MAX_LEN) : size;
    assign w_segInRange   = ({1'b0, seg_pos}   < (PW+1)'(NPIX));
    assign w_appleInRange = ({1'b0, apple_pos} < (PW+1)'(NPIX));
    assign w_isHead       = (r_pendIdx == '0);
    // A blinking head is suppressed on odd frames so it flashes at half the frame rate.
    assign w_writeSeg     = w_segInRange && !(w_isHead && blink && r_parity);
    assign w_lastFetch    = (LW'(r_index) == (r_len - LW'(1)));

    assign seg_addr   = (r_state == S_FETCH) ? r_index : '0;
    assign busy       = (r_state != S_IDLE);
    assign leds       = r_leds;
    assign frame_done = r_frameDone;
    assign collision  = r_collision;
    assign apple_hit  = r_appleHit;
    assign pos_error  = r_posError;

    always_ff @(posedge clock or negedge restart) begin
        if (!restart) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_leds      <= '0;
            r_len       <= '0;
            r_index     <= '0;
            r_pendIdx   <= '0;
            r_pend      <= 1'b0;
            r_parity    <= 1'b0;
            r_colScr    <= 1'b0;
            r_hitScr    <= 1'b0;
            r_errScr    <= 1'b0;
            r_frameDone <= 1'b0;
            r_collision <= 1'b0;
            r_appleHit  <= 1'b0;
            r_posError  <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            r_pend      <= 1'b0;

            // seg_pos arriving now belongs to the address issued on the previous cycle.
            if (r_pend) begin
                if (!w_segInRange) begin
                    r_errScr <= 1'b1;
                end else begin
                    if (!w_isHead && r_work[seg_pos]) begin
                        r_colScr <= 1'b1;
                    end
                    if (w_writeSeg) begin
                        r_work[seg_pos] <= 1'b1;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_work   <= '0;
                    r_index  <= '0;
                    r_colScr <= 1'b0;
                    r_hitScr <= 1'b0;
                    r_errScr <= 1'b0;
                    r_len    <= w_lenClamp;
                    r_state  <= (w_lenClamp != '0) ? S_FETCH : S_APPLE;
                end
                S_FETCH: begin
                    r_pend    <= 1'b1;
                    r_pendIdx <= r_index;
                    if (w_lastFetch) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_index <= r_index + AW'(1);
                    end
                end
                S_DRAIN: begin
                    r_state <= S_APPLE;
                end
                S_APPLE: begin
                    if (apple_en) begin
                        if (w_appleInRange) begin
                            r_hitScr           <= r_work[apple_pos];
                            r_work[apple_pos]  <= 1'b1;
                        end else begin
                            r_errScr <= 1'b1;
                        end
                    end
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_leds      <= r_work;
                    r_collision <= r_colScr;
                    r_appleHit  <= r_hitScr;
                    r_posError  <= r_errScr;
                    r_frameDone <= 1'b1;
                    r_parity    <= ~r_parity;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_frame_render.sv
// Directed bench for snake_frame_render: a sync-read body memory model feeds the DUT,
// expected frames are queued per render and checked when frame_done pulses.
module tb_snake_frame_render;

    logic        clock;
    logic        restart;
    logic        start;
    logic [4:0]  size;
    logic [3:0]  seg_addr;
    logic [5:0]  seg_pos;
    logic [5:0]  apple_pos;
    logic        apple_en;
    logic        blink;
    logic [35:0] leds;
    logic        busy;
    logic        frame_done;
    logic        collision;
    logic        apple_hit;
    logic        pos_error;

    typedef struct {
        logic [35:0] leds;
        logic        col;
        logic        hit;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [5:0]  mem [0:15];
    int          total = 0;
    int          bad = 0;
    int          doneCount = 0;
    logic [3:0]  maxAddr = '0;
    logic        addrClr = 1'b0;

    snake_frame_render dut (
        .clock      (clock),
        .restart    (restart),
        .start      (start),
        .size       (size),
        .seg_addr   (seg_addr),
        .seg_pos    (seg_pos),
        .apple_pos  (apple_pos),
        .apple_en   (apple_en),
        .blink      (blink),
        .leds       (leds),
        .busy       (busy),
        .frame_done (frame_done),
        .collision  (collision),
        .apple_hit  (apple_hit),
        .pos_error  (pos_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Body memory with one-cycle synchronous read.
    always @(posedge clock) seg_pos <= mem[seg_addr];

    always @(negedge clock) begin
        if (frame_done) doneCount <= doneCount + 1;
        if (addrClr) maxAddr <= '0;
        else if (seg_addr > maxAddr) maxAddr <= seg_addr;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Launches one render, optionally pokes start again while busy, and checks the committed frame.
    task automatic applyStimulus(input string tag, input logic [4:0] sz, input logic [35:0] eLeds,
                                 input logic eCol, input logic eHit, input logic eErr,
                                 input int eLat, input bit pokeWhileBusy);
        exp_t e;
        exp_t got;
        int   n;
        bit   seen;
        e.leds = eLeds;
        e.col  = eCol;
        e.hit  = eHit;
        e.err  = eErr;
        e.lat  = eLat;
        sb.push_back(e);
        seen = 1'b0;
        n = 0;
        @(negedge clock);
        size  = sz;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        while (n < 100 && !seen) begin
            @(posedge clock);
            #1;
            n++;
            if (pokeWhileBusy && n == 1) start = 1'b1;
            if (pokeWhileBusy && n == 2) start = 1'b0;
            if (frame_done) seen = 1'b1;
        end
        got = sb.pop_front();
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
        checkOutput({tag, "_latency"}, 64'(n), 64'(got.lat));
        checkOutput({tag, "_leds"}, 64'(leds), 64'(got.leds));
        checkOutput({tag, "_collision"}, 64'(collision), 64'(got.col));
        checkOutput({tag, "_apple_hit"}, 64'(apple_hit), 64'(got.hit));
        checkOutput({tag, "_pos_error"}, 64'(pos_error), 64'(got.err));
        checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        checkOutput({tag, "_done_pulse"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        int doneBefore;
        restart   = 1'b0;
        start     = 1'b0;
        size      = '0;
        apple_pos = '0;
        apple_en  = 1'b0;
        blink     = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_leds", 64'(leds), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(frame_done), 64'd0);
        checkOutput("rst_seg_addr", 64'(seg_addr), 64'd0);
        @(negedge clock);
        restart = 1'b1;

        mem[0] = 6'd14; mem[1] = 6'd15; mem[2] = 6'd16;
        apple_en = 1'b1; apple_pos = 6'd0;
        applyStimulus("basic", 5'd3, (36'd1 << 0) | (36'd1 << 14) | (36'd1 << 15) | (36'd1 << 16),
                      1'b0, 1'b0, 1'b0, 7, 1'b0);

        mem[0] = 6'd7; mem[1] = 6'd8; mem[2] = 6'd7; mem[3] = 6'd9;
        apple_en = 1'b0;
        applyStimulus("selfhit", 5'd4, (36'd1 << 7) | (36'd1 << 8) | (36'd1 << 9),
                      1'b1, 1'b0, 1'b0, 8, 1'b0);

        mem[0] = 6'd20;
        blink = 1'b1;
        applyStimulus("blink1", 5'd1, 36'd1 << 20, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        applyStimulus("blink2", 5'd1, 36'd0,       1'b0, 1'b0, 1'b0, 5, 1'b0);
        applyStimulus("blink3", 5'd1, 36'd1 << 20, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        applyStimulus("blink4", 5'd1, 36'd0,       1'b0, 1'b0, 1'b0, 5, 1'b0);
        blink = 1'b0;

        mem[0] = 6'd5; mem[1] = 6'd6;
        apple_en = 1'b1; apple_pos = 6'd6;
        applyStimulus("applehit", 5'd2, (36'd1 << 5) | (36'd1 << 6), 1'b0, 1'b1, 1'b0, 6, 1'b0);

        mem[0] = 6'd40; mem[1] = 6'd3;
        apple_en = 1'b0;
        applyStimulus("segrange", 5'd2, 36'd1 << 3, 1'b0, 1'b0, 1'b1, 6, 1'b0);

        for (int i = 0; i < 16; i++) mem[i] = 6'(i + 10);
        apple_en = 1'b1; apple_pos = 6'd40;
        @(negedge clock);
        addrClr = 1'b1;
        @(negedge clock);
        addrClr = 1'b0;
        applyStimulus("clamp", 5'd20, ((36'd1 << 16) - 36'd1) << 10, 1'b0, 1'b0, 1'b1, 20, 1'b0);
        checkOutput("clamp_max_addr", 64'(maxAddr), 64'd15);

        for (int i = 0; i < 16; i++) mem[i] = 6'(i);
        apple_en = 1'b0;
        doneBefore = doneCount;
        @(negedge clock);
        size  = 5'd10;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        restart = 1'b0;
        #1;
        checkOutput("midrst_leds", 64'(leds), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(frame_done), 64'd0);
        checkOutput("midrst_pos_error", 64'(pos_error), 64'd0);
        checkOutput("midrst_seg_addr", 64'(seg_addr), 64'd0);
        @(negedge clock);
        restart = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("midrst_no_commit", 64'(doneCount - doneBefore), 64'd0);
        applyStimulus("after_rst", 5'd10, 36'h3FF, 1'b0, 1'b0, 1'b0, 14, 1'b0);

        apple_en = 1'b1; apple_pos = 6'd35;
        doneBefore = doneCount;
        applyStimulus("zero_len", 5'd0, 36'd1 << 35, 1'b0, 1'b0, 1'b0, 3, 1'b1);
        repeat (4) @(negedge clock);
        checkOutput("ignored_start_busy", 64'(busy), 64'd0);
        checkOutput("ignored_start_frames", 64'(doneCount - doneBefore), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
